regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single register-file write port between the ALU writeback path and the load-store unit, and tracks outstanding load destinations in a scoreboard so decode can stall on read-after-write and write-after-write hazards. It sits between the execute/LSU stages and the register file's write interface (`wr_port_ip`/`wr_data_ip`/`ctrl_reg_wr_en_ip`). It also drives the decode-stage stall for operands still owed by an in-flight load.

## Interface
- `MAX_OUTSTANDING`, 4: maximum loads tracked in flight (1..15).
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `alu_valid_ip` input 1: ALU writeback request.
- `alu_rd_ip` input 5: ALU destination register.
- `alu_data_ip` input 32: ALU result.
- `alu_ready_op` output 1: ALU request granted this cycle.
- `ld_valid_ip` input 1: load-data writeback request.
- `ld_rd_ip` input 5: load destination register.
- `ld_data_ip` input 32: load data.
- `ld_ready_op` output 1: load request granted this cycle.
- `issue_ld_ip` input 1: decode issues a load this cycle.
- `issue_rd_ip` input 5: destination of the issuing load.
- `chk_rs1_ip`, `chk_rs2_ip`, `chk_rd_ip` input 5 each: registers of the instruction in decode.
- `stall_op` output 1: decode must hold.
- `sb_full_op` output 1: outstanding-load count equals `MAX_OUTSTANDING`.
- `wr_port_op` output 5, `wr_data_op` output 32, `ctrl_reg_wr_en_op` output 1: register-file write interface.

## Operation
- **Arbitration**
  - Round-robin between the two requesters using a 1-bit `last_grant` register (ALU=0, LD=1).
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last is granted. `last_grant` updates on every grant.
  - Exactly one of `alu_ready_op`/`ld_ready_op` is high per cycle at most, and a ready is never asserted without the matching valid.
  - A requester holds valid/rd/data stable until it sees ready.
- **Write output**
  - On a grant, the rd/data pair is registered into `wr_port_op`/`wr_data_op`.
  - `ctrl_reg_wr_en_op` is set to 1 unless rd is 0. Writes to x0 are consumed but produce `ctrl_reg_wr_en_op`=0.
  - With no grant, `ctrl_reg_wr_en_op` is 0 and port/data hold their previous value.
- **Scoreboard**
  - A 32-bit `busy` vector tracks loads in flight; `busy[0]` is always 0.
  - `issue_ld_ip` with `issue_rd_ip`≠0 sets `busy[issue_rd_ip]`.
  - A load grant clears `busy[ld_rd_ip]` in the same edge that registers the write.
  - If the set and the clear hit the same register in the same cycle, the set wins.
- **Outstanding counter**
  - 4-bit counter: +1 on `issue_ld_ip` (including rd=0), −1 on a load grant. Simultaneous increment and decrement leaves it unchanged.
  - `sb_full_op` = (count == `MAX_OUTSTANDING`).
  - `issue_ld_ip` while full is a protocol error: it is ignored (no busy set, no increment) and flagged by a simulation assertion.
  - A load grant at count 0 is an error: the counter saturates at 0 and the assertion fires.
- **Stall**
  - `stall_op` = `busy[chk_rs1_ip]` | `busy[chk_rs2_ip]` | `busy[chk_rd_ip]` | (`issue_ld_ip` & `sb_full_op`).
  - Index 0 never stalls.

## Timing
- **Reset values:** `ctrl_reg_wr_en_op`=0, `wr_port_op`=0, `wr_data_op`=0, `busy`=0, count=0, `last_grant`=1 so the ALU wins the first tie. Combinationally during `rst`: `alu_ready_op`=`ld_ready_op`=0, `stall_op`=0, `sb_full_op`=0.
- **Reset mid-operation:** a pending grant in the cycle `rst` is high is discarded and no write is produced next cycle; all scoreboard state is cleared.
- **Ready path:** `*_ready_op`, `stall_op` and `sb_full_op` are combinational from the inputs and current state, with no registered delay.
- **Write latency:** 1 cycle from grant to `ctrl_reg_wr_en_op`.
- **Scoreboard release:** a busy bit clears on the same edge the write is registered. In the next cycle `stall_op` drops, and the register file's same-cycle write bypass supplies the data.
- **Throughput:** one write per cycle. A requester that is continuously valid waits at most one cycle behind the other.

## Structure
- **Shared package (`cpu_pkg`):** `REG_ADDR_W`=5, `XLEN`=32, and the `GRANT_ALU`/`GRANT_LD` encoding.
- **Sub-module:** `reg_scoreboard`, containing the busy vector, outstanding counter, full flag and stall logic. The round-robin arbiter and write register stay in the top module.

## Test plan
- **Reset:** `rst` high 2 cycles, then release with no requests → all outputs 0, `stall_op`=0.
- **Tie-break fairness:** ALU valid (rd=5, 0xAAAA_0001) and LD valid (rd=6, 0x5555_0002) both held → grants alternate ALU, LD, ALU. `ctrl_reg_wr_en_op` follows one cycle later with port 5, then 6.
- **x0 write:** ALU writes rd=0, data 0xDEAD_BEEF → `alu_ready_op`=1, next cycle `ctrl_reg_wr_en_op`=0.
- **Load hazard:** issue load rd=7, then `chk_rs1_ip`=7 → `stall_op`=1 until the LD grant for rd=7; `stall_op`=0 the cycle after the grant.
- **Set/clear collision:** LD grant for rd=9 coincides with `issue_ld_ip` rd=9 → `busy[9]` stays 1 and count is unchanged.
- **Full:** 4 loads issued with no returns → `sb_full_op`=1; a 5th `issue_ld_ip` raises `stall_op` and leaves count at 4. Reset in the next cycle → count 0 and `sb_full_op`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the writeback arbiter and its load scoreboard.
//   REG_ADDR_W : width of a register-file index (x0..x31)
//   XLEN       : datapath width
//   grant_e    : which requester owned the write port last (ALU or load)
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_e;

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Tracks destination registers of loads that have been issued but whose data
// has not yet been written back, and tells decode when it must hold.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_issueLd, i_issueRd   : decode issues a load to register i_issueRd
//   i_ldGrant, i_ldRd      : load writeback granted for register i_ldRd
//   i_chkRs1/Rs2/Rd        : registers used by the instruction in decode
//   o_stall                : decode must hold this cycle
//   o_sbFull               : MAX_OUTSTANDING loads are already in flight
// ---------------------------------------------------------------------------
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_issueLd,
  input  logic [REG_ADDR_W-1:0] i_issueRd,
  input  logic                  i_ldGrant,
  input  logic [REG_ADDR_W-1:0] i_ldRd,
  input  logic [REG_ADDR_W-1:0] i_chkRs1,
  input  logic [REG_ADDR_W-1:0] i_chkRs2,
  input  logic [REG_ADDR_W-1:0] i_chkRd,
  output logic                  o_stall,
  output logic                  o_sbFull
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [31:0] r_busy;
  logic [3:0]  r_count;
  logic [31:0] w_busyNext;
  logic        w_full;
  logic        w_issueOk;
  logic        w_countDec;

  // An issue while full is dropped entirely; a grant at zero cannot underflow.
  assign w_full     = (r_count == MAX_CNT);
  assign w_issueOk  = i_issueLd & ~w_full;
  assign w_countDec = i_ldGrant & (r_count != 4'd0);

  // Next busy vector: the returning load clears its bit first, then a new
  // issue to the same register sets it again, so the newer load still owns
  // the register. Bit 0 is forced low since x0 never carries a hazard.
  always_comb begin
    w_busyNext = r_busy;
    if (i_ldGrant) begin
      w_busyNext[i_ldRd] = 1'b0;
    end
    if (w_issueOk && (i_issueRd != '0)) begin
      w_busyNext[i_issueRd] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  // Busy vector and outstanding-load counter. Issues to x0 still count,
  // because the load will still come back and take a write slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy <= w_busyNext;
      if (w_issueOk && !w_countDec) begin
        r_count <= r_count + 4'd1;
      end else if (w_countDec && !w_issueOk) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  // Protocol checks on the upstream stages; these only report, the datapath
  // above already makes both cases harmless.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      issueWhileFull : assert (!(i_issueLd && w_full))
        else $warning("reg_scoreboard: load issued while scoreboard full, issue dropped");
      grantWhileEmpty : assert (!(i_ldGrant && (r_count == 4'd0)))
        else $warning("reg_scoreboard: load writeback with no load outstanding");
    end
  end

  // Stall is purely combinational so decode sees it in the same cycle; all
  // status is forced quiet while reset is held.
  assign o_sbFull = ~i_rst & w_full;
  assign o_stall  = ~i_rst & (r_busy[i_chkRs1] | r_busy[i_chkRs2] | r_busy[i_chkRd] |
                              (i_issueLd & w_full));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU writeback path
// and the load-store unit (round robin), registers the winning write, and
// hosts the load scoreboard that stalls decode on pending load destinations.
//   clk, rst                                 : clock, sync active-high reset
//   alu_valid_ip/alu_rd_ip/alu_data_ip       : ALU writeback request
//   alu_ready_op                             : ALU request granted this cycle
//   ld_valid_ip/ld_rd_ip/ld_data_ip          : load writeback request
//   ld_ready_op                              : load request granted this cycle
//   issue_ld_ip/issue_rd_ip                  : decode issues a load
//   chk_rs1_ip/chk_rs2_ip/chk_rd_ip          : registers of decode instruction
//   stall_op, sb_full_op                     : decode hold, scoreboard full
//   wr_port_op/wr_data_op/ctrl_reg_wr_en_op  : register-file write interface
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid_ip,
  input  logic [REG_ADDR_W-1:0] alu_rd_ip,
  input  logic [XLEN-1:0]       alu_data_ip,
  output logic                  alu_ready_op,
  input  logic                  ld_valid_ip,
  input  logic [REG_ADDR_W-1:0] ld_rd_ip,
  input  logic [XLEN-1:0]       ld_data_ip,
  output logic                  ld_ready_op,
  input  logic                  issue_ld_ip,
  input  logic [REG_ADDR_W-1:0] issue_rd_ip,
  input  logic [REG_ADDR_W-1:0] chk_rs1_ip,
  input  logic [REG_ADDR_W-1:0] chk_rs2_ip,
  input  logic [REG_ADDR_W-1:0] chk_rd_ip,
  output logic                  stall_op,
  output logic                  sb_full_op,
  output logic [REG_ADDR_W-1:0] wr_port_op,
  output logic [XLEN-1:0]       wr_data_op,
  output logic                  ctrl_reg_wr_en_op
);

  grant_e                r_lastGrant;
  logic                  r_wrEn;
  logic [REG_ADDR_W-1:0] r_wrPort;
  logic [XLEN-1:0]       r_wrData;
  logic                  w_aluGrant;
  logic                  w_ldGrant;

  // Round-robin grant: a lone requester always wins; on a tie the side that
  // did not win last time goes. Nothing is granted while reset is held so a
  // request in that cycle never turns into a write.
  always_comb begin
    w_aluGrant = 1'b0;
    w_ldGrant  = 1'b0;
    if (!rst) begin
      if (alu_valid_ip && ld_valid_ip) begin
        if (r_lastGrant == GRANT_LD) begin
          w_aluGrant = 1'b1;
        end else begin
          w_ldGrant = 1'b1;
        end
      end else begin
        w_aluGrant = alu_valid_ip;
        w_ldGrant  = ld_valid_ip;
      end
    end
  end

  // Write register and round-robin history. Reset leaves last grant at LD so
  // the ALU wins the first tie. Writes to x0 are accepted but the enable is
  // held low; with no grant, port and data keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= GRANT_LD;
      r_wrEn      <= 1'b0;
      r_wrPort    <= '0;
      r_wrData    <= '0;
    end else if (w_aluGrant) begin
      r_lastGrant <= GRANT_ALU;
      r_wrEn      <= (alu_rd_ip != '0);
      r_wrPort    <= alu_rd_ip;
      r_wrData    <= alu_data_ip;
    end else if (w_ldGrant) begin
      r_lastGrant <= GRANT_LD;
      r_wrEn      <= (ld_rd_ip != '0);
      r_wrPort    <= ld_rd_ip;
      r_wrData    <= ld_data_ip;
    end else begin
      r_wrEn <= 1'b0;
    end
  end

  // The scoreboard releases a destination on the same edge the load data is
  // written, so the stall drops one cycle later and the register file bypass
  // supplies the value.
  reg_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_scoreboard (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_issueLd (issue_ld_ip),
    .i_issueRd (issue_rd_ip),
    .i_ldGrant (w_ldGrant),
    .i_ldRd    (ld_rd_ip),
    .i_chkRs1  (chk_rs1_ip),
    .i_chkRs2  (chk_rs2_ip),
    .i_chkRd   (chk_rd_ip),
    .o_stall   (stall_op),
    .o_sbFull  (sb_full_op)
  );

  assign alu_ready_op      = w_aluGrant;
  assign ld_ready_op       = w_ldGrant;
  assign ctrl_reg_wr_en_op = r_wrEn;
  assign wr_port_op        = r_wrPort;
  assign wr_data_op        = r_wrData;

endmodule
